// File: rtl/pk_controlador_pkg.sv
// -----------------------------------------------------------------------------
// pk_controlador_pkg
//   Shared constants and types for the pk sequencer.
//   PK_N      : sample/result width (signed fixed point)
//   PK_LAT    : pipeline registers ahead of the datapath's enabled output reg
//   PK_CNT_W  : default width of the acknowledged-sample counter
//   pkc_state_t : sequencer state encoding (also exported as a debug port)
// -----------------------------------------------------------------------------
package pk_controlador_pkg;

  localparam int PK_N     = 18;
  localparam int PK_LAT   = 2;
  localparam int PK_CNT_W = 16;

  typedef enum logic [1:0] {
    PKC_IDLE   = 2'd0,
    PKC_ESPERA = 2'd1,
    PKC_CARGA  = 2'd2,
    PKC_VALIDO = 2'd3
  } pkc_state_t;

endpackage

// File: rtl/pk_controlador_buffer.sv
// -----------------------------------------------------------------------------
// pk_buffer_muestra
//   One-entry sample buffer that holds a strobe arriving while the sequencer
//   is busy.
//   clk, reset : clock and synchronous active-high reset (empties the entry)
//   push, din  : store din; push has priority so push+pop refills the entry
//   pop        : release the entry (dout is consumed by the caller this cycle)
//   dout       : stored sample
//   full       : entry holds a sample
// -----------------------------------------------------------------------------
module pk_buffer_muestra #(
  parameter int N = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      full <= 1'b0;
    end else if (push) begin
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pk_controlador.sv
// -----------------------------------------------------------------------------
// pk_controlador
//   Sequencer for the pk datapath (yk -> FFD1 -> x18 -> FFD2 -> trunc -> out reg).
//   Launches a sample on yk_out, waits LATENCIA cycles for the pipeline to
//   fill, pulses enable_pk once so the output register captures the product of
//   that sample, then presents pk_valido until downstream acknowledges.
//
//   Ports
//     clk, reset        : clock, synchronous active-high reset
//     muestra_lista     : 1-cycle strobe, yk_in valid this cycle
//     yk_in             : signed sample from upstream
//     yk_out            : sample driven to the datapath, changes only on launch
//     enable_pk         : datapath output-register enable, 1-cycle pulse
//     pk_valido         : datapath pk belongs to the held sample
//     pk_tomado         : downstream ack
//     ocupado           : sequencer not idle
//     desborde          : sticky, a sample was dropped
//     borrar_desborde   : clears desborde (a simultaneous drop wins)
//     cuenta_muestras   : acknowledged samples since reset, wraps silently
//     estado            : current sequencer state (debug)
//
//   Handshake: a result transfer happens in exactly the cycles where
//   pk_valido=1 and pk_tomado=1 at the rising edge; pk_tomado with
//   pk_valido=0 has no effect, and pk_valido falls the cycle after the
//   transfer unless a new result is presented.
// -----------------------------------------------------------------------------
module pk_controlador
  import pk_controlador_pkg::*;
#(
  parameter int N        = PK_N,
  parameter int LATENCIA = PK_LAT,
  parameter int CNT_W    = PK_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             muestra_lista,
  input  logic [N-1:0]     yk_in,
  output logic [N-1:0]     yk_out,
  output logic             enable_pk,
  output logic             pk_valido,
  input  logic             pk_tomado,
  output logic             ocupado,
  output logic             desborde,
  input  logic             borrar_desborde,
  output logic [CNT_W-1:0] cuenta_muestras,
  output pkc_state_t       estado
);

  localparam int CW = $clog2(LATENCIA + 1);
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(LATENCIA - 1);

  pkc_state_t      state;
  logic [CW-1:0]   cnt;

  logic            buf_full;
  logic [N-1:0]    buf_dout;
  logic            ack;
  logic            buf_pop;
  logic            lanzar_directo;
  logic            strobe_ocupado;
  logic            buf_push;
  logic            descartar;

  // Ack is only meaningful while a result is presented.
  assign ack            = (state == PKC_VALIDO) && pk_tomado;
  assign buf_pop        = ack && buf_full;
  // With an empty buffer, a strobe coinciding with the ack launches at once.
  assign lanzar_directo = ack && !buf_full && muestra_lista;
  assign strobe_ocupado = muestra_lista && (state != PKC_IDLE) && !lanzar_directo;
  // A pop in the same cycle frees the entry, so the new strobe refills it
  // instead of being lost.
  assign buf_push       = strobe_ocupado && (!buf_full || buf_pop);
  assign descartar      = strobe_ocupado && buf_full && !buf_pop;

  pk_buffer_muestra #(
    .N (N)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (yk_in),
    .dout  (buf_dout),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= PKC_IDLE;
      cnt             <= '0;
      yk_out          <= '0;
      enable_pk       <= 1'b0;
      pk_valido       <= 1'b0;
      cuenta_muestras <= '0;
    end else begin
      enable_pk <= 1'b0;
      case (state)
        PKC_IDLE: begin
          if (muestra_lista) begin
            yk_out <= yk_in;
            cnt    <= '0;
            state  <= PKC_ESPERA;
          end
        end
        PKC_ESPERA: begin
          // enable_pk is registered, so it is raised on the way into CARGA.
          if (cnt == CNT_ULTIMO) begin
            enable_pk <= 1'b1;
            state     <= PKC_CARGA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PKC_CARGA: begin
          pk_valido <= 1'b1;
          state     <= PKC_VALIDO;
        end
        PKC_VALIDO: begin
          if (pk_tomado) begin
            pk_valido       <= 1'b0;
            cuenta_muestras <= cuenta_muestras + CNT_W'(1);
            cnt             <= '0;
            if (buf_full) begin
              yk_out <= buf_dout;
              state  <= PKC_ESPERA;
            end else if (muestra_lista) begin
              yk_out <= yk_in;
              state  <= PKC_ESPERA;
            end else begin
              state <= PKC_IDLE;
            end
          end
        end
        default: state <= PKC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      desborde <= 1'b0;
    end else if (descartar) begin
      desborde <= 1'b1;
    end else if (borrar_desborde) begin
      desborde <= 1'b0;
    end
  end

  assign ocupado = (state != PKC_IDLE);
  assign estado  = state;

endmodule

// File: tb/tb_pk_controlador.sv
// -----------------------------------------------------------------------------
// tb_pk_controlador
//   Drives pk_controlador together with a behavioural pk datapath
//   (yk -> FFD1 -> x18 -> FFD2 -> low-N truncation -> enabled output reg).
//   Expected pk values are pushed when a sample is issued and popped by a
//   monitor on every accepted transfer (pk_valido && pk_tomado).
// -----------------------------------------------------------------------------
module tb_pk_controlador;
  import pk_controlador_pkg::*;

  localparam int N     = 18;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             muestra_lista = 1'b0;
  logic [N-1:0]     yk_in = '0;
  logic [N-1:0]     yk_out;
  logic             enable_pk;
  logic             pk_valido;
  logic             pk_tomado = 1'b0;
  logic             ocupado;
  logic             desborde;
  logic             borrar_desborde = 1'b0;
  logic [CNT_W-1:0] cuenta_muestras;
  pkc_state_t       estado;

  pk_controlador #(
    .N        (N),
    .LATENCIA (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .muestra_lista   (muestra_lista),
    .yk_in           (yk_in),
    .yk_out          (yk_out),
    .enable_pk       (enable_pk),
    .pk_valido       (pk_valido),
    .pk_tomado       (pk_tomado),
    .ocupado         (ocupado),
    .desborde        (desborde),
    .borrar_desborde (borrar_desborde),
    .cuenta_muestras (cuenta_muestras),
    .estado          (estado)
  );

  // ---------------- behavioural pk datapath ----------------
  logic [N-1:0]   ffd1;
  logic [N+4:0]   ffd2;
  logic [N-1:0]   pk;

  always @(posedge clk) begin
    if (reset) begin
      ffd1 <= '0;
      ffd2 <= '0;
      pk   <= '0;
    end else begin
      ffd1 <= yk_out;
      ffd2 <= $signed({{5{ffd1[N-1]}}, ffd1}) * 23'sd18;
      if (enable_pk) pk <= ffd2[N-1:0];
    end
  end

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && pk_valido && pk_tomado) begin
      if (exp_q.size() == 0) begin
        check("pk_unexpected", {14'd0, pk}, 32'hFFFF_FFFF);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check("pk", {14'd0, pk}, {14'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are applied just after the rising edge; the caller checks outputs
  // at the following falling edge and then calls fin().
  task automatic drive(input logic s, input logic [N-1:0] y, input logic ack,
                       input logic auto_ack, input logic clr);
    muestra_lista   = s;
    yk_in           = y;
    pk_tomado       = ack | (auto_ack & pk_valido);
    borrar_desborde = clr;
    @(negedge clk);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    muestra_lista   = 1'b0;
    pk_tomado       = 1'b0;
    borrar_desborde = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Reset state
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_yk_out", yk_out, 0);
    check("rst_enable", enable_pk, 0);
    check("rst_valido", pk_valido, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_desborde", desborde, 0);
    check("rst_cuenta", cuenta_muestras, 0);
    fin();

    // 1: single sample 100 -> 1800, ack in cyc6
    exp_q.push_back(18'd1800);
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, 18'd100, c == 6, 1'b0, 1'b0);
      check("t1_enable", enable_pk, c == 3);
      check("t1_valido", pk_valido, (c >= 4) && (c <= 6));
      if (c == 1) check("t1_yk_out", yk_out, 18'd100);
      if (c == 7) begin
        check("t1_idle", ocupado, 0);
        check("t1_cuenta", cuenta_muestras, 1);
      end
      fin();
    end

    // 2: back-to-back 5, -7 with immediate ack
    exp_q.push_back(18'd90);
    exp_q.push_back(18'h3FF82);  // -126
    for (int c = 0; c < 11; c++) begin
      drive((c == 0) || (c == 2), (c == 0) ? 18'd5 : 18'h3FFF9, 1'b0, 1'b1, 1'b0);
      check("t2_enable", enable_pk, (c == 3) || (c == 7));
      check("t2_desborde", desborde, 0);
      if (c == 5) check("t2_yk_out", yk_out, 18'h3FFF9);
      if (c == 10) begin
        check("t2_idle", ocupado, 0);
        check("t2_cuenta", cuenta_muestras, 3);
      end
      fin();
    end

    // 3: overrun 1,2,3 with no ack until cyc5; 3 is dropped
    exp_q.push_back(18'd18);
    exp_q.push_back(18'd36);
    for (int c = 0; c < 15; c++) begin
      drive(c < 3, 18'(c + 1), 1'b0, c >= 5, c == 12);
      check("t3_desborde", desborde, (c >= 3) && (c <= 12));
      check("t3_enable", enable_pk, (c == 3) || (c == 8));
      if (c == 6) check("t3_yk_out", yk_out, 18'd2);
      if (c == 14) begin
        check("t3_idle", ocupado, 0);
        check("t3_cuenta", cuenta_muestras, 5);
      end
      fin();
    end

    // 4: ack + strobe same cycle, buffer empty, min value launched directly
    exp_q.push_back(18'd180);
    exp_q.push_back(18'd0);  // -131072*18 truncated to 18 bits
    for (int c = 0; c < 10; c++) begin
      drive((c == 0) || (c == 4), (c == 0) ? 18'd10 : 18'h20000, 1'b0, 1'b1, 1'b0);
      check("t4_enable", enable_pk, (c == 3) || (c == 7));
      if (c == 4) check("t4_valido", pk_valido, 1);
      if (c == 5) check("t4_yk_out", yk_out, 18'h20000);
      if (c == 9) begin
        check("t4_idle", ocupado, 0);
        check("t4_cuenta", cuenta_muestras, 7);
      end
      fin();
    end

    // 5: reset mid-flight, second strobe buffered then flushed
    drive(1'b1, 18'd77, 1'b0, 1'b0, 1'b0);
    fin();
    drive(1'b1, 18'd88, 1'b0, 1'b0, 1'b0);
    fin();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    fin();
    reset = 1'b0;
    for (int c = 3; c < 7; c++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("t5_enable", enable_pk, 0);
      check("t5_ocupado", ocupado, 0);
      if (c == 3) begin
        check("t5_yk_out", yk_out, 0);
        check("t5_valido", pk_valido, 0);
        check("t5_desborde", desborde, 0);
        check("t5_cuenta", cuenta_muestras, 0);
      end
      fin();
    end
    exp_q.push_back(18'd3600);
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 18'd200, c == 4, 1'b0, 1'b0);
      check("t5b_enable", enable_pk, c == 3);
      if (c >= 5) begin
        check("t5b_idle", ocupado, 0);
        check("t5b_cuenta", cuenta_muestras, 1);
      end
      fin();
    end

    // 6: 17 acked samples wrap a 4-bit counter to 1
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      logic got;
      got = 1'b0;
      exp_q.push_back(18'(18 * i));
      drive(1'b1, 18'(i), 1'b0, 1'b0, 1'b0);
      fin();
      for (int k = 0; k < 10; k++) begin
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        got = pk_tomado;
        fin();
        if (got) break;
      end
      check("t6_result_seen", got, 1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t6_wrap", cuenta_muestras, 1);
    fin();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      fin();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t6_spurious_ack", cuenta_muestras, 1);
    check("t6_idle", ocupado, 0);
    fin();

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
